// File: rtl/io_poller_pkg.sv
// Shared definitions for the I/O poller: FSM state encoding and the
// memory-mapped I/O addresses it drives onto the bus.
// Optional event logging is enabled by defining IO_POLLER_LOG_EN.
package io_poller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_RD_SW,
    S_WR_LED,
    S_WR_NUM,
    S_WR_LET
`ifdef IO_POLLER_LOG_EN
    , S_LOG
`endif
  } state_t;

  localparam logic [31:0] ADDR_SW    = 32'hC000_0000;
  localparam logic [31:0] ADDR_LED   = 32'hC000_0004;
  localparam logic [31:0] ADDR_NUM   = 32'hC000_0008;
  localparam logic [31:0] ADDR_LET   = 32'hC000_000C;
  localparam logic [31:0] ADDR_ENTER = 32'hC000_0010;

endpackage

// File: rtl/io_poller_rise_detect.sv
// Rising-edge detector for the Enter button. The history flop powers up
// (and can be forced) to 1 so a button already held down is never
// mistaken for a fresh press.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic set_one,
  input  logic d,
  output logic rise
);

  logic q_reg;

  // History of the last sampled level; forced high after a served press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       q_reg <= 1'b1;
    else if (set_one) q_reg <= 1'b1;
    else if (sample)  q_reg <= d;
  end

  assign rise = sample & d & ~q_reg;

endmodule

// File: rtl/io_poller.sv
// Bus master that polls the Enter button and, on each new press, copies the
// switch word to the LED, number and letter display registers.
// Define IO_POLLER_LOG_EN to also append a record of each press to a
// circular log in data RAM at LOG_BASE.
module io_poller
  import io_poller_pkg::*;
#(
  parameter logic [31:0] LOG_BASE  = 32'h0000_0080,
  parameter int          LOG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] rd,
  output logic [31:0] a,
  output logic [31:0] wd,
  output logic        we,
  output logic        busy,
  output logic [7:0]  press_count
);

  localparam int PTR_W = $clog2(LOG_DEPTH);

  state_t      state_reg, state_next;
  logic [9:0]  sw_reg;
  logic [7:0]  press_count_reg;
  logic        sample, set_one, rise, last;

`ifdef IO_POLLER_LOG_EN
  logic [PTR_W-1:0] wr_ptr_reg;
`endif

  // Upper read-data bits and the log parameters are not needed in every build.
  logic unused_bits;
  assign unused_bits = ^{rd[31:10], LOG_BASE[1:0], LOG_DEPTH[0]};

  rise_detect u_rise (
    .clk     (clk),
    .reset   (reset),
    .sample  (sample),
    .set_one (set_one),
    .d       (rd[0]),
    .rise    (rise)
  );

  // Next-state and bus outputs for the current state.
  always_comb begin
    state_next = state_reg;
    a          = ADDR_ENTER;
    wd         = 32'h0;
    we         = 1'b0;
    sample     = 1'b0;
    set_one    = 1'b0;
    last       = 1'b0;
    case (state_reg)
      S_IDLE: if (en) state_next = S_POLL;
      S_POLL: begin
        sample = 1'b1;
        if (rise) state_next = S_RD_SW;
      end
      S_RD_SW: begin
        a          = ADDR_SW;
        state_next = S_WR_LED;
      end
      S_WR_LED: begin
        a          = ADDR_LED;
        we         = 1'b1;
        wd         = {22'b0, sw_reg};
        state_next = S_WR_NUM;
      end
      S_WR_NUM: begin
        a          = ADDR_NUM;
        we         = 1'b1;
        wd         = {24'b0, sw_reg[7:0]};
        state_next = S_WR_LET;
      end
      S_WR_LET: begin
        a  = ADDR_LET;
        we = 1'b1;
        wd = {30'b0, sw_reg[9:8]};
`ifdef IO_POLLER_LOG_EN
        state_next = S_LOG;
`else
        last = 1'b1;
`endif
      end
`ifdef IO_POLLER_LOG_EN
      S_LOG: begin
        a    = LOG_BASE + {{(30-PTR_W){1'b0}}, wr_ptr_reg, 2'b00};
        we   = 1'b1;
        wd   = {press_count_reg, 14'b0, sw_reg};
        last = 1'b1;
      end
`endif
      default: state_next = S_IDLE;
    endcase
    // The sequence always runs to completion; en is only consulted here.
    if (last) begin
      state_next = en ? S_POLL : S_IDLE;
      set_one    = en;
    end
  end

  // State, latched switches, press counter and log pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      sw_reg          <= 10'h0;
      press_count_reg <= 8'h0;
`ifdef IO_POLLER_LOG_EN
      wr_ptr_reg      <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == S_RD_SW)  sw_reg <= rd[9:0];
      if (state_reg == S_WR_LET) press_count_reg <= press_count_reg + 8'd1;
`ifdef IO_POLLER_LOG_EN
      if (state_reg == S_LOG)    wr_ptr_reg <= wr_ptr_reg + 1'b1;
`endif
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign press_count = press_count_reg;

endmodule

// File: tb/tb_io_poller.sv
// Directed bench for io_poller: a table of switch patterns walked through
// full press sequences, plus hand-written held-Enter, en-drop and
// mid-sequence reset scenarios. Works with or without IO_POLLER_LOG_EN.
module tb_io_poller;
  import io_poller_pkg::*;

`ifdef IO_POLLER_LOG_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        enter = 1'b0;
  logic [9:0]  sw = 10'h0;
  logic [31:0] rd, a, wd;
  logic        we, busy;
  logic [7:0]  press_count;

  int total = 0;
  int passed = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [9:0]  sw;
    logic [31:0] led;
    logic [31:0] num;
    logic [31:0] let_d;
    logic [7:0]  pc;
    logic [31:0] log_a;
    logic [31:0] log_d;
  } vec_t;

  vec_t vt[5];

  io_poller #(.LOG_BASE(32'h0000_0080), .LOG_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .rd          (rd),
    .a           (a),
    .wd          (wd),
    .we          (we),
    .busy        (busy),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  // Memory-mapped I/O model: Enter and switch registers, combinational read.
  assign rd = (a == ADDR_ENTER) ? {31'b0, enter} :
              (a == ADDR_SW)    ? {22'b0, sw}    : 32'h0;

  // Count bus write strobes, one per cycle.
  always @(negedge clk) if (we === 1'b1) wr_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Hold Enter low long enough for POLL to see it, then raise it.
  task automatic arm_and_press();
    enter = 1'b0;
    cyc(); cyc(); cyc();
    enter = 1'b1;
    cyc();
  endtask

  initial begin
    vt[0] = '{10'h2A5, 32'h2A5, 32'hA5, 32'h2, 8'd1, 32'h80, 32'h0100_02A5};
    vt[1] = '{10'h000, 32'h000, 32'h00, 32'h0, 8'd2, 32'h84, 32'h0200_0000};
    vt[2] = '{10'h3FF, 32'h3FF, 32'hFF, 32'h3, 8'd3, 32'h88, 32'h0300_03FF};
    vt[3] = '{10'h155, 32'h155, 32'h55, 32'h1, 8'd4, 32'h8C, 32'h0400_0155};
    vt[4] = '{10'h2CA, 32'h2CA, 32'hCA, 32'h2, 8'd5, 32'h80, 32'h0500_02CA};

    // Reset state, asserted asynchronously
    #3;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_a", a, ADDR_ENTER);
    chk("rst_wd", wd, 32'h0);
    chk("rst_pc", {24'b0, press_count}, 32'h0);
    cyc();
    reset = 1'b1;
    chk("rel_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_busy", {31'b0, busy}, 32'h0);
      chk("idle_we", {31'b0, we}, 32'h0);
      chk("idle_a", a, ADDR_ENTER);
    end
    chk("idle_pc", {24'b0, press_count}, 32'h0);
    $display("txn idle10 busy=%0d press_count=%0d", busy, press_count);

    en = 1'b1;
    cyc();
    chk("poll_busy", {31'b0, busy}, 32'h1);
    chk("poll_we", {31'b0, we}, 32'h0);

    // Table-driven full sequences
    for (int i = 0; i < 5; i++) begin
      sw = vt[i].sw;
      arm_and_press();
      chk("rdsw_a", a, ADDR_SW);
      chk("rdsw_we", {31'b0, we}, 32'h0);
      cyc();
      chk("led_a", a, ADDR_LED);
      chk("led_we", {31'b0, we}, 32'h1);
      chk("led_wd", wd, vt[i].led);
      cyc();
      chk("num_a", a, ADDR_NUM);
      chk("num_we", {31'b0, we}, 32'h1);
      chk("num_wd", wd, vt[i].num);
      cyc();
      chk("let_a", a, ADDR_LET);
      chk("let_we", {31'b0, we}, 32'h1);
      chk("let_wd", wd, vt[i].let_d);
      cyc();
`ifdef IO_POLLER_LOG_EN
      chk("log_a", a, vt[i].log_a);
      chk("log_we", {31'b0, we}, 32'h1);
      chk("log_wd", wd, vt[i].log_d);
      cyc();
`endif
      chk("end_we", {31'b0, we}, 32'h0);
      chk("end_a", a, ADDR_ENTER);
      chk("end_pc", {24'b0, press_count}, {24'b0, vt[i].pc});
      $display("txn press %0d sw=%h press_count=%0d", i, vt[i].sw, press_count);
    end

    // Enter held high for 20 cycles: exactly one sequence
    enter = 1'b0;
    cyc(); cyc(); cyc();
    wr_cnt = 0;
    enter = 1'b1;
    repeat (20) cyc();
    chk("held_writes", wr_cnt, NW);
    chk("held_pc", {24'b0, press_count}, 32'd6);
    arm_and_press();
    repeat (8) cyc();
    chk("repress_pc", {24'b0, press_count}, 32'd7);
    $display("txn held press_count=%0d writes=%0d", press_count, wr_cnt);

    // en dropped during WR_LED: sequence completes, then IDLE
    arm_and_press();
    cyc();
    chk("drop_led_we", {31'b0, we}, 32'h1);
    en = 1'b0;
    cyc();
    chk("drop_num_a", a, ADDR_NUM);
    chk("drop_num_we", {31'b0, we}, 32'h1);
    cyc();
    chk("drop_let_a", a, ADDR_LET);
    chk("drop_let_we", {31'b0, we}, 32'h1);
`ifdef IO_POLLER_LOG_EN
    cyc();
    chk("drop_log_we", {31'b0, we}, 32'h1);
`endif
    cyc();
    chk("drop_busy", {31'b0, busy}, 32'h0);
    chk("drop_we", {31'b0, we}, 32'h0);
    chk("drop_pc", {24'b0, press_count}, 32'd8);
    $display("txn en_drop busy=%0d press_count=%0d", busy, press_count);

    // Reset asserted during WR_NUM
    en = 1'b1;
    arm_and_press();
    cyc();
    cyc();
    chk("prerst_num_a", a, ADDR_NUM);
    reset = 1'b0;
    #1;
    wr_cnt = 0;
    chk("midrst_we", {31'b0, we}, 32'h0);
    chk("midrst_a", a, ADDR_ENTER);
    chk("midrst_wd", wd, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_pc", {24'b0, press_count}, 32'h0);
    repeat (3) cyc();
    chk("midrst_nowrite", wr_cnt, 0);
    reset = 1'b1;
    chk("midrst_rel_busy", {31'b0, busy}, 32'h0);
    cyc();
    chk("midrst_poll_busy", {31'b0, busy}, 32'h1);
    chk("midrst_pc2", {24'b0, press_count}, 32'h0);
    $display("txn mid_reset press_count=%0d", press_count);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_poller.md
IO_POLLER -- requirements
Module: io_poller

Interface
REQ-001 Parameter LOG_BASE, default 32'h0000_0080, word-aligned RAM byte address of the event log.
REQ-002 Parameter LOG_DEPTH, default 16, number of 32-bit log words; power of two, 2..64.
REQ-003 clk  input  1  rising-edge clock shared with the data memory.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  run request; high lets the poller leave IDLE.
REQ-006 rd  input  32  read data returned by the data memory for address a (combinational, same cycle).
REQ-007 a  output  32  bus byte address.
REQ-008 wd  output  32  bus write data.
REQ-009 we  output  1  bus write strobe, one cycle per write.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 press_count  output  8  number of completed Enter events, wraps 255->0.

Function
REQ-012 Poller SHALL be the bus initiator for the memory-mapped I/O map: switches 0xC000_0000 (read), LEDs 0xC000_0004, display number 0xC000_0008, display letter 0xC000_000C (write), Enter 0xC000_0010 (read).
REQ-013 States SHALL be IDLE, POLL, RD_SW, WR_LED, WR_NUM, WR_LET, LOG; one cycle each except IDLE and POLL.
REQ-014 IDLE: a=0xC000_0010, we=0, wd=0; en=1 -> POLL next cycle.
REQ-015 POLL: a=0xC000_0010, we=0; each cycle register rd[0] into enter_q; rising edge (rd[0]=1, enter_q=0) -> RD_SW.
REQ-016 Enter held high SHALL NOT retrigger; a new event requires rd[0]=0 sampled in POLL first.
REQ-017 RD_SW: a=0xC000_0000, we=0; latch sw=rd[9:0] at end of cycle.
REQ-018 WR_LED: a=0xC000_0004, we=1, wd={22'b0,sw}.
REQ-019 WR_NUM: a=0xC000_0008, we=1, wd={24'b0,sw[7:0]}.
REQ-020 WR_LET: a=0xC000_000C, we=1, wd={28'b0,2'b00,sw[9:8]}; press_count increments at end of this cycle.
REQ-021 LOG (feature on only): a=LOG_BASE+4*wr_ptr, we=1, wd={press_count_new, 14'b0, sw}; wr_ptr increments, wraps LOG_DEPTH-1 -> 0.
REQ-022 After last write state -> POLL if en=1, else IDLE; en falling mid-sequence SHALL NOT abort the sequence.
REQ-023 Edge-to-first-write latency: 2 cycles (edge seen in POLL, RD_SW, WR_LED write at 3rd clk edge); full sequence 5 cycles with log, 4 without.
REQ-024 enter_q SHALL be set to 1 on return to POLL so the just-served press is not re-detected.
REQ-025 we SHALL be 0 in IDLE, POLL, RD_SW.

Reset
REQ-026 reset low SHALL immediately force IDLE, we=0, a=0xC000_0010, wd=0, busy=0, press_count=0, sw=0, enter_q=1, wr_ptr=0, including mid-sequence.
REQ-027 Release SHALL be synchronous to clk via the async-assert flops; first state change no earlier than the first clk edge after release.

Configuration
REQ-028 Macro IO_POLLER_LOG_EN defined: LOG state and wr_ptr present, sequence WR_LET -> LOG -> POLL/IDLE.
REQ-029 Macro IO_POLLER_LOG_EN undefined: no LOG state, no wr_ptr, WR_LET -> POLL/IDLE; RAM never written.

Structure
REQ-030 Package io_poller_pkg SHALL hold the state enum and the five I/O address constants.
REQ-031 Sub-module rise_detect SHALL implement the enter_q register and rising-edge output with set-to-1 load.

Verification
REQ-032 Reset, en=0 -> busy=0, we=0, a=0xC000_0010, press_count=0 for 10 cycles.
REQ-033 en=1, switches=10'h2A5, Enter 0->1 -> writes LED 0x2A5, NUM 0xA5, LET 0x2 in consecutive cycles; press_count=1.
REQ-034 Enter held high 20 cycles after one press -> exactly one sequence; release then press -> press_count=2.
REQ-035 LOG_EN, LOG_DEPTH=4, 5 presses -> log writes at 0x80,0x84,0x88,0x8C,0x80; 5th wd[31:24]=5.
REQ-036 en dropped during WR_LED -> WR_NUM, WR_LET(, LOG) complete, then IDLE, busy=0.
REQ-037 reset asserted during WR_NUM -> we=0 same cycle, no WR_LET write, press_count=0.
